// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pkg
// Description : Shared constants and state encodings for the frame sequencer
//               and the display side.
// Revision    : 1.0 - initial release
// ============================================================================
package mandel_pkg;

    localparam int COORD_W   = 12;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    // Life cycle of one engine slot
    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_RUN   = 2'd2,
        SLOT_PEND  = 2'd3
    } slot_state_t;

    // Frame-level sequencer states
    typedef enum logic [1:0] {
        FSM_IDLE     = 2'd0,
        FSM_DISPATCH = 2'd1,
        FSM_DRAIN    = 2'd2,
        FSM_DONE     = 2'd3
    } frame_state_t;

endpackage : mandel_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. One-hot grant to the first requester at
//               or after the rotating pointer; pointer moves to winner+1 when
//               the grant is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_accept,
    output logic [N-1:0] o_grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = IW + 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_idx;
    logic [SW-1:0] w_sum;
    logic          w_any;

    // Search requesters starting at the pointer, wrapping modulo N
    always_comb begin
        o_grant = '0;
        w_win   = '0;
        w_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_any && i_req[w_idx]) begin
                w_any          = 1'b1;
                w_win          = w_idx;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

    // Rotate the pointer past the winner once its grant is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept && w_any) begin
            r_ptr <= (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scheduler
// Description : Raster-order frame sequencer. Dispatches pixels to a bank of
//               iteration engines, collects saturated results and writes
//               them to the frame buffer through a registered write port.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int HBI         = 32,
    parameter int PIX_W       = 8,
    parameter int ADDR_W      = 19
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           frame_start,
    output logic                           busy,
    output logic                           frame_done,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [COORD_W*NUM_ENGINES-1:0] eng_x,
    output logic [COORD_W*NUM_ENGINES-1:0] eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [HBI*NUM_ENGINES-1:0]     eng_iteration,
    output logic                           fb_we,
    output logic [ADDR_W-1:0]              fb_addr,
    output logic [PIX_W-1:0]               fb_data,
    input  logic                           fb_ready
);

    localparam int                 IDX_W   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [HBI-1:0]     PIX_MAX = HBI'((2 ** PIX_W) - 1);
    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_RES - 1);

    // Frame sequencer and raster
    frame_state_t           r_state;
    logic [COORD_W-1:0]     r_x;
    logic [COORD_W-1:0]     r_y;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_busy;
    logic                   r_frame_done;
    logic [NUM_ENGINES-1:0] r_eng_start;

    // Per-slot context
    slot_state_t            r_slot_st   [NUM_ENGINES];
    logic                   r_arm_cnt   [NUM_ENGINES];
    logic [COORD_W-1:0]     r_slot_x    [NUM_ENGINES];
    logic [COORD_W-1:0]     r_slot_y    [NUM_ENGINES];
    logic [ADDR_W-1:0]      r_slot_addr [NUM_ENGINES];
    logic [PIX_W-1:0]       r_slot_pix  [NUM_ENGINES];

    // Frame-buffer write stage
    logic                   r_fb_we;
    logic [ADDR_W-1:0]      r_fb_addr;
    logic [PIX_W-1:0]       r_fb_data;
    logic [IDX_W-1:0]       r_wr_slot;

    logic [NUM_ENGINES-1:0] w_free;
    logic [NUM_ENGINES-1:0] w_req;
    logic [NUM_ENGINES-1:0] w_grant;
    logic [PIX_W-1:0]       w_sat [NUM_ENGINES];
    logic [IDX_W-1:0]       w_disp_idx;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_disp;
    logic                   w_load;
    logic                   w_wr_accept;
    logic                   w_last_pix;
    logic                   w_all_free;

    assign w_load      = !r_fb_we || fb_ready;
    assign w_wr_accept = r_fb_we && fb_ready;
    assign w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_all_free  = &w_free;
    assign w_disp      = (r_state == FSM_DISPATCH) && (|w_free);

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign eng_start  = r_eng_start;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;

    // Lowest-index free slot receives the next pixel
    always_comb begin
        w_disp_idx = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_disp_idx = IDX_W'(i);
            end
        end
    end

    // Encode the one-hot write grant into a slot index
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (w_grant[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
            logic [HBI-1:0] w_iter;

            assign w_iter   = eng_iteration[i*HBI +: HBI];
            assign w_sat[i] = (w_iter > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : w_iter[PIX_W-1:0];
            assign w_free[i] = (r_slot_st[i] == SLOT_FREE);
            // A slot already sitting in the write stage must not be granted again
            assign w_req[i]  = (r_slot_st[i] == SLOT_PEND) &&
                               !(r_fb_we && (r_wr_slot == IDX_W'(i)));
            assign eng_x[i*COORD_W +: COORD_W] = r_slot_x[i];
            assign eng_y[i*COORD_W +: COORD_W] = r_slot_y[i];

            // Slot life cycle; ARMED lasts two cycles to hide the stale done level
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_slot_st[i]   <= SLOT_FREE;
                    r_arm_cnt[i]   <= 1'b0;
                    r_slot_x[i]    <= '0;
                    r_slot_y[i]    <= '0;
                    r_slot_addr[i] <= '0;
                    r_slot_pix[i]  <= '0;
                end else begin
                    case (r_slot_st[i])
                        SLOT_FREE: begin
                            if (w_disp && (w_disp_idx == IDX_W'(i))) begin
                                r_slot_st[i]   <= SLOT_ARMED;
                                r_arm_cnt[i]   <= 1'b0;
                                r_slot_x[i]    <= r_x;
                                r_slot_y[i]    <= r_y;
                                r_slot_addr[i] <= r_addr;
                            end
                        end
                        SLOT_ARMED: begin
                            if (r_arm_cnt[i]) begin
                                r_slot_st[i] <= SLOT_RUN;
                            end else begin
                                r_arm_cnt[i] <= 1'b1;
                            end
                        end
                        SLOT_RUN: begin
                            if (eng_done[i]) begin
                                r_slot_st[i]  <= SLOT_PEND;
                                r_slot_pix[i] <= w_sat[i];
                            end
                        end
                        SLOT_PEND: begin
                            if (w_wr_accept && (r_wr_slot == IDX_W'(i))) begin
                                r_slot_st[i] <= SLOT_FREE;
                            end
                        end
                        default: r_slot_st[i] <= SLOT_FREE;
                    endcase
                end
            end
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_ENGINES)
    ) u_wr_arb (
        .clk      (CLK),
        .rst      (RST),
        .i_req    (w_req),
        .i_accept (w_load),
        .o_grant  (w_grant)
    );

    // Frame sequencer: raster walk, dispatch pulses, busy and frame_done
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= FSM_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_eng_start  <= '0;
        end else begin
            r_eng_start  <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                FSM_IDLE: begin
                    if (frame_start) begin
                        r_state <= FSM_DISPATCH;
                        r_busy  <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                    end
                end
                FSM_DISPATCH: begin
                    if (w_disp) begin
                        r_eng_start[w_disp_idx] <= 1'b1;
                        if (w_last_pix) begin
                            r_state <= FSM_DRAIN;
                        end else begin
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                r_y <= r_y + 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                FSM_DRAIN: begin
                    if (w_all_free) begin
                        r_state      <= FSM_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                FSM_DONE: begin
                    r_state <= FSM_IDLE;
                end
                default: r_state <= FSM_IDLE;
            endcase
        end
    end

    // Write stage: load the granted slot whenever the stage is empty or draining
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
            r_wr_slot <= '0;
        end else if (w_load) begin
            if (|w_req) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= r_slot_addr[w_win_idx];
                r_fb_data <= r_slot_pix[w_win_idx];
                r_wr_slot <= w_win_idx;
            end else begin
                r_fb_we <= 1'b0;
            end
        end
    end

endmodule : pixel_scheduler
`default_nettype wire

// File: tb/tb_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_scheduler
// Description : Scoreboard bench for pixel_scheduler on a 4x2 frame with two
//               modelled engines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_scheduler;

    localparam int N      = 2;
    localparam int H      = 4;
    localparam int V      = 2;
    localparam int HBI    = 32;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 4;
    localparam int NPIX   = H * V;

    logic              CLK;
    logic              RST;
    logic              frame_start;
    logic              busy;
    logic              frame_done;
    logic [N-1:0]      eng_start;
    logic [12*N-1:0]   eng_x;
    logic [12*N-1:0]   eng_y;
    logic [N-1:0]      eng_done;
    logic [HBI*N-1:0]  eng_iteration;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_data;
    logic              fb_ready;

    pixel_scheduler #(
        .NUM_ENGINES (N),
        .H_RES       (H),
        .V_RES       (V),
        .HBI         (HBI),
        .PIX_W       (PIX_W),
        .ADDR_W      (ADDR_W)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .frame_start   (frame_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .eng_start     (eng_start),
        .eng_x         (eng_x),
        .eng_y         (eng_y),
        .eng_done      (eng_done),
        .eng_iteration (eng_iteration),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_ready      (fb_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t sb[$];
    int   wr_log[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   e1_cnt   = 0;

    // Engine model state
    int          lat      [N];
    int          iter_tab [NPIX];
    int          exp_tab  [NPIX];
    logic [N-1:0] m_done;
    logic [31:0] m_iter [N];
    int          m_cnt  [N];
    int          m_px   [N];
    int          m_py   [N];

    assign eng_done      = m_done;
    assign eng_iteration = {m_iter[1], m_iter[0]};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Engine models: done after lat cycles; done stays high (stale) until restarted
    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (RST) begin
                m_done[i] <= 1'b1;
                m_iter[i] <= 32'd1000;
                m_cnt[i]  <= 0;
            end else if (eng_start[i]) begin
                m_done[i] <= 1'b0;
                m_iter[i] <= 32'hDEAD_BEEF;
                m_cnt[i]  <= lat[i];
                m_px[i]   <= int'(eng_x[i*12 +: 12]);
                m_py[i]   <= int'(eng_y[i*12 +: 12]);
            end else if (!m_done[i]) begin
                if (m_cnt[i] <= 1) begin
                    m_done[i] <= 1'b1;
                    m_iter[i] <= 32'(iter_tab[m_py[i]*H + m_px[i]]);
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    // Monitor: match every accepted write against the outstanding expectations
    always @(negedge CLK) begin
        int found;
        if (!RST) begin
            if (frame_done) done_cnt++;
            if (eng_start[1]) e1_cnt++;
            if (fb_we && fb_ready) begin
                found = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (found < 0 && sb[j].addr == int'(fb_addr)) found = j;
                end
                wr_log.push_back(int'(fb_addr));
                if (found < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_addr: got addr %0d, required an outstanding address", fb_addr);
                end else begin
                    chk("wr_data", int'(fb_data), sb[found].data);
                    sb.delete(found);
                end
            end
        end
    end

    task automatic load_tables(input int t);
        int it [NPIX];
        int ex [NPIX];
        case (t)
            1: begin
                it = '{17, 300, 0, 255, 256, 1, 1000, 42};
                ex = '{17, 255, 0, 255, 255, 1, 255, 42};
            end
            3: begin
                it = '{100, 200, 3, 4, 500, 60, 70, 80};
                ex = '{100, 200, 3, 4, 255, 60, 70, 80};
            end
            default: begin
                it = '{5, 6, 7, 8, 9, 10, 11, 12};
                ex = '{5, 6, 7, 8, 9, 10, 11, 12};
            end
        endcase
        for (int k = 0; k < NPIX; k++) begin
            iter_tab[k] = it[k];
            exp_tab[k]  = ex[k];
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        sb.delete();
    endtask

    task automatic start_frame();
        wr_log.delete();
        done_cnt = 0;
        e1_cnt   = 0;
        for (int k = 0; k < NPIX; k++) sb.push_back('{addr: k, data: exp_tab[k]});
        frame_start = 1'b1;
        @(posedge CLK);
        #1;
        frame_start = 1'b0;
    endtask

    // Returns cycles from the frame_start edge to the first visible fb_we
    task automatic first_write_latency(output int n);
        n = 1;
        while (!fb_we && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        n = n - 1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 3000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("frame_done_seen", int'(frame_done), 1);
        chk("busy_in_done", int'(busy), 0);
        @(posedge CLK);
        #1;
        chk("frame_done_low", int'(frame_done), 0);
        chk("busy_after", int'(busy), 0);
        chk("done_pulses", done_cnt, 1);
        chk("sb_left", sb.size(), 0);
        chk("writes", wr_log.size(), NPIX);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_eng_x", int'(eng_x), 0);
        chk("rst_eng_y", int'(eng_y), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int found;
        RST         = 1'b1;
        frame_start = 1'b0;
        fb_ready    = 1'b1;
        lat[0]      = 3;
        lat[1]      = 3;
        load_tables(1);
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs();
        RST = 1'b0;

        // Basic frame with saturation; a frame_start while busy is ignored
        start_frame();
        first_write_latency(n);
        chk("latency_lat3", n, 7);
        frame_start = 1'b1;
        @(posedge CLK);
        #1;
        frame_start = 1'b0;
        wait_done();

        // Unequal engine latencies: engine 1 handles most pixels, out of order
        lat[0] = 20;
        lat[1] = 2;
        load_tables(3);
        start_frame();
        wait_done();
        chk("first_wr_addr", wr_log[0], 1);
        chk("eng1_pixels", e1_cnt, 6);

        // Write back-pressure with both slots pending
        do_reset();
        lat[0] = 3;
        lat[1] = 3;
        load_tables(1);
        fb_ready = 1'b0;
        start_frame();
        repeat (9) @(posedge CLK);
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("stall_we", int'(fb_we), 1);
            chk("stall_addr", int'(fb_addr), 0);
            chk("stall_data", int'(fb_data), 17);
            chk("stall_no_start", int'(eng_start), 0);
            @(posedge CLK);
            #1;
        end
        fb_ready = 1'b1;
        wait_done();
        chk("rr_order0", wr_log[0], 0);
        chk("rr_order1", wr_log[1], 1);

        // Stale done level held at dispatch must not be captured
        do_reset();
        lat[0] = 4;
        lat[1] = 4;
        load_tables(5);
        start_frame();
        first_write_latency(n);
        chk("latency_lat4", n, 8);
        wait_done();

        // Mid-frame reset at pixel 3, then a clean frame
        do_reset();
        lat[0] = 3;
        lat[1] = 3;
        load_tables(1);
        start_frame();
        n     = 0;
        found = 0;
        while (!found && n < 200) begin
            if ((eng_start[0] && eng_x[11:0] == 12'd3 && eng_y[11:0] == 12'd0) ||
                (eng_start[1] && eng_x[23:12] == 12'd3 && eng_y[23:12] == 12'd0)) begin
                found = 1;
            end else begin
                @(posedge CLK);
                #1;
                n++;
            end
        end
        chk("pix3_dispatched", found, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk_reset_outputs();
        RST = 1'b0;
        sb.delete();
        start_frame();
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pixel_scheduler
`default_nettype wire
